mem_model_mp: RTL and testbench
===============================

// Module: mem_model_mp
// PURPOSE
//  Multi-port, byte-enabled, word-addressed memory model for the ASI slave bench and future multi-master benches.
//  Generalises the single-port model in three ways: any lane count, NPORTS independent ports, and a read pipeline
//  with per-port valid strobes.
//  Defines read-during-write and write-collision semantics; sits behind ASI user ports (m_we/m_addr/m_wstrb).
// PARAMETERS
//  NBYTES   16    byte lanes per word (any value >=1)
//  BW       8     bits per lane
//  DEPTH    1024  words; need not be a power of 2
//  NPORTS   2     independent access ports
//  RD_WS    0     read wait states; 0 = combinational read data
//  RDW_MODE 0     same-cycle read/write to same word: 0 = read old data, 1 = read new (byte-merged) data
//  derived: AW=$clog2(DEPTH), DW=NBYTES*BW
// PORTS
//  clk       in   1                 clock
//  rst       in   1                 synchronous, active-high reset
//  req       in   [NPORTS]          access request; always accepted (no backpressure)
//  we        in   [NPORTS]          1 = write, 0 = read (qualified by req)
//  addr      in   [NPORTS][AW]      word address
//  be        in   [NPORTS][NBYTES]  byte enables (writes only)
//  wdata     in   [NPORTS][DW]      write data
//  rvalid    out  [NPORTS]          read data valid strobe
//  rdata     out  [NPORTS][DW]      read data
//  coll_err  out  1                 sticky write-collision flag (see CONFIGURATION)
// BEHAVIOUR
//  - Reset values: rvalid=0, rdata=0, coll_err=0, all read-pipe stages invalid.
//  - RAM contents are not cleared by rst; they initialise to 0 at time 0.
//  - Writes are suppressed while rst=1.
//  - Write: req&we at edge k updates lanes with be[i]=1 at edge k; be=0 is a legal no-op.
//  - Read RD_WS=0: rvalid=req&~we and rdata=ram[addr], both combinational in the same cycle.
//  - Read RD_WS=N>0: data sampled at edge k; rvalid/rdata presented after edge k+N-1, i.e. N cycles of latency.
//    Pipeline is fully pipelined, 1 read/cycle/port, in-order.
//    rdata holds its last value while rvalid=0.
//  - Read-during-write, different ports, same word, same cycle:
//    RDW_MODE=0 returns pre-write word; RDW_MODE=1 returns word with the writer's enabled lanes merged in.
//  - Write-write, same word, same cycle: per lane, lowest-index port with be set wins.
//    Lanes enabled by only one port take that port's data.
//  - addr>=DEPTH: write ignored; read returns 0 with rvalid asserted normally.
//  - rst mid-operation: all in-flight reads are dropped; rvalid=0 from the cycle after rst rises until new reads mature.
// CONFIGURATION
//  MEM_MODEL_MP_COLLISION_CHK_EN defined:
//    - Any cycle with two ports writing the same word with overlapping be sets coll_err (sticky until rst).
//    - The same cycle issues $error with port indices and address.
//    - Write resolution is unchanged.
//  Undefined: coll_err tied 0, no check logic or messages.
// STRUCTURE
//  - Package mem_model_pkg: rdw_mode_e {RDW_OLD, RDW_NEW}; lane_t = logic [BW-1:0];
//    function merge_be(old, new, be) shared by write resolution and RDW_NEW.
//  - Sub-module mem_rd_pipe: per-port valid+data shift register of depth RD_WS;
//    generate-bypassed (combinational) when RD_WS=0. One instance per port.
//  - Lane writes use a generate loop over NBYTES.
// TESTING
//  1 NBYTES=16,RD_WS=0: P0 write addr 5 be=0x00FF data=0x..11.., P0 read 5 same next cycle
//    -> low 8 lanes new, high lanes 0, rvalid same cycle.
//  2 RD_WS=3: P1 back-to-back reads of addr 0..7 -> rvalid on 8 consecutive cycles starting 3 cycles later;
//    data in order.
//  3 RDW_MODE=0 vs 1: P0 writes addr 9 = 0xAA.. while P1 reads addr 9 (old 0x55..)
//    -> mode0 returns 0x55.., mode1 returns 0xAA..
//  4 Collision: P0 be=0x000F data A, P1 be=0x00FF data B, addr 3 same cycle
//    -> lanes 0-3 = A, lanes 4-7 = B; coll_err=1 only with MEM_MODEL_MP_COLLISION_CHK_EN.
//  5 RD_WS=2: issue read, assert rst 1 cycle later -> no rvalid for that read;
//    next read after rst returns correct data 2 cycles later.
//  6 DEPTH=1000: write addr 1000 then read 1000 -> rdata=0, rvalid=1; addr 999 unaffected.

Source files
------------

// File: rtl/mem_model_pkg.sv
// mem_model_pkg: shared types and lane-merge helper
// for the multi-port memory model.
package mem_model_pkg;

  typedef enum logic {
    RDW_OLD = 1'b0,
    RDW_NEW = 1'b1
  } rdw_mode_e;

  localparam int LANE_W = 8;
  typedef logic [LANE_W-1:0] lane_t;

  // widest word the merge helper handles
  localparam int MAX_DW = 1024;
  typedef logic [MAX_DW-1:0] wide_t;

  // lanes of new_w with be set replace those of old_w;
  // be is the lane-enable vector, zero-extended
  function automatic wide_t merge_be(
    input wide_t old_w,
    input wide_t new_w,
    input wide_t be,
    input int    bw
  );
    wide_t m;
    for (int b = 0; b < MAX_DW; b++) begin
      m[b] = be[b / bw];
    end
    return (old_w & ~m) | (new_w & m);
  endfunction

endpackage

// File: rtl/mem_model_mp_rd_pipe.sv
// mem_rd_pipe: per-port read valid/data delay line,
// bypassed to a wire when N is 0.
module mem_rd_pipe
  import mem_model_pkg::*;
#(
  parameter int DW = 128,
  parameter int N  = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data
);

  if (N == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid = in_valid;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic [N-1:0]  v;
    logic [DW-1:0] d [N];

    // shift reads through N stages; data only
    // moves with a valid so the output holds
    always_ff @(posedge clk) begin
      if (rst) begin
        v <= '0;
        for (int i = 0; i < N; i++) begin
          d[i] <= '0;
        end
      end else begin
        v[0] <= in_valid;
        if (in_valid) begin
          d[0] <= in_data;
        end
        for (int i = 1; i < N; i++) begin
          v[i] <= v[i-1];
          if (v[i-1]) begin
            d[i] <= d[i-1];
          end
        end
      end
    end

    assign out_valid = v[N-1];
    assign out_data  = d[N-1];
  end

endmodule

// File: rtl/mem_model_mp.sv
// mem_model_mp: multi-port byte-enabled memory model.
// Optional MEM_MODEL_MP_COLLISION_CHK_EN: sticky coll_err.
module mem_model_mp
  import mem_model_pkg::*;
#(
  parameter int NBYTES   = 16,
  parameter int BW       = 8,
  parameter int DEPTH    = 1024,
  parameter int NPORTS   = 2,
  parameter int RD_WS    = 0,
  parameter int RDW_MODE = 0,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int DW = NBYTES * BW
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NPORTS-1:0]              req,
  input  logic [NPORTS-1:0]              we,
  input  logic [NPORTS-1:0][AW-1:0]      addr,
  input  logic [NPORTS-1:0][NBYTES-1:0]  be,
  input  logic [NPORTS-1:0][DW-1:0]      wdata,
  output logic [NPORTS-1:0]              rvalid,
  output logic [NPORTS-1:0][DW-1:0]      rdata,
  output logic                           coll_err
);

  localparam rdw_mode_e MODE = rdw_mode_e'(RDW_MODE[0]);

  logic [NPORTS-1:0]         in_rng;
  logic [NPORTS-1:0]         wen;
  logic [NPORTS-1:0]         ren;
  logic [NPORTS-1:0][DW-1:0] old_w;
  logic [NPORTS-1:0][DW-1:0] new_w;
  logic [NPORTS-1:0][DW-1:0] rd_w;

  // qualify strobes: range check, rst blocks all access
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      in_rng[p] = {1'b0, addr[p]} < (AW+1)'(DEPTH);
      wen[p] = req[p] & we[p] & in_rng[p] & ~rst;
      ren[p] = req[p] & ~we[p] & ~rst;
    end
  end

  // word at each port's address after this cycle's
  // writes; folding high to low lets port 0 win lanes
  always_comb begin
    wide_t acc;
    for (int p = 0; p < NPORTS; p++) begin
      acc = MAX_DW'(old_w[p]);
      for (int q = NPORTS - 1; q >= 0; q--) begin
        if (wen[q] && addr[q] == addr[p]) begin
          acc = merge_be(acc, MAX_DW'(wdata[q]),
                         MAX_DW'(be[q]), BW);
        end
      end
      new_w[p] = acc[DW-1:0];
    end
  end

  // storage split per lane; power-up contents are the
  // simulator's zero initial value (no reset clears it)
  for (genvar i = 0; i < NBYTES; i++) begin : g_lane
    logic [BW-1:0] lane_mem [DEPTH];

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
      assign old_w[p][i*BW +: BW] =
        in_rng[p] ? lane_mem[addr[p]] : '0;
    end

    // every writer of a word commits the same resolved lane
    always_ff @(posedge clk) begin
      for (int p = 0; p < NPORTS; p++) begin
        if (wen[p] && be[p][i]) begin
          lane_mem[addr[p]] <= new_w[p][i*BW +: BW];
        end
      end
    end
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    assign rd_w[p] = (MODE == RDW_NEW) ? new_w[p] : old_w[p];

    mem_rd_pipe #(
      .DW (DW),
      .N  (RD_WS)
    ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (ren[p]),
      .in_data   (rd_w[p]),
      .out_valid (rvalid[p]),
      .out_data  (rdata[p])
    );
  end

`ifdef MEM_MODEL_MP_COLLISION_CHK_EN
  logic coll_now;

  // two writers, same word, overlapping lanes
  always_comb begin
    coll_now = 1'b0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = p + 1; q < NPORTS; q++) begin
        if (wen[p] && wen[q] && addr[p] == addr[q] &&
            |(be[p] & be[q])) begin
          coll_now = 1'b1;
        end
      end
    end
  end

  // sticky flag, cleared only by rst
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_err <= 1'b0;
    end else if (coll_now) begin
      coll_err <= 1'b1;
    end
  end

  // name the colliding ports and word
  always_ff @(posedge clk) begin
    for (int p = 0; p < NPORTS; p++) begin
      for (int q = p + 1; q < NPORTS; q++) begin
        if (wen[p] && wen[q] && addr[p] == addr[q] &&
            |(be[p] & be[q])) begin
          $error("mem_model_mp: write collision ports %0d/%0d addr %0d",
                 p, q, addr[p]);
        end
      end
    end
  end
`else
  assign coll_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_model_mp.sv
// tb_mem_model_mp: two configurations driven in lockstep,
// checked by a scoreboard against a lane-level memory model.
module tb_mem_model_mp;

  localparam int NB = 16;
  localparam int DW = 128;
  localparam int NP = 2;
  localparam int AW = 10;

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]         req = '0;
  logic [NP-1:0]         we = '0;
  logic [NP-1:0][AW-1:0] addr = '0;
  logic [NP-1:0][NB-1:0] be = '0;
  logic [NP-1:0][DW-1:0] wdata = '0;
  logic [1:0][NP-1:0]         rvalid;
  logic [1:0][NP-1:0][DW-1:0] rdata;
  logic [1:0]                 coll;

  logic [NP-1:0]         n_req;
  logic [NP-1:0]         n_we;
  logic [NP-1:0][AW-1:0] n_addr;
  logic [NP-1:0][NB-1:0] n_be;
  logic [NP-1:0][DW-1:0] n_wd;

  logic [DW-1:0] mdl [2][1024];
  logic [DW-1:0] last [2][NP];
  exp_t          sq [4][$];
  logic [1:0]    coll_exp = '0;
  logic [1:0]    coll_pend = '0;
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  bit  mon_on = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: combinational read, old data on RDW
  mem_model_mp #(
    .NBYTES(16), .BW(8), .DEPTH(1024), .NPORTS(2),
    .RD_WS(0), .RDW_MODE(0)
  ) u_a (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr(addr), .be(be), .wdata(wdata),
    .rvalid(rvalid[0]), .rdata(rdata[0]),
    .coll_err(coll[0])
  );

  // instance 1: 3 wait states, new data, short depth
  mem_model_mp #(
    .NBYTES(16), .BW(8), .DEPTH(1000), .NPORTS(2),
    .RD_WS(3), .RDW_MODE(1)
  ) u_b (
    .clk(clk), .rst(rst), .req(req), .we(we),
    .addr(addr), .be(be), .wdata(wdata),
    .rvalid(rvalid[1]), .rdata(rdata[1]),
    .coll_err(coll[1])
  );

  function automatic int dep(input int k);
    return (k == 0) ? 1024 : 1000;
  endfunction

  function automatic int ws(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string nm,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%h want=%h",
               nm, $time, act, exp);
    end
  endtask

  // word at a after the current inputs' writes land:
  // each lane taken by the lowest-numbered port enabling it
  function automatic logic [DW-1:0] after_wr(input int k,
                                             input int a);
    logic [DW-1:0] w;
    bit [NB-1:0]   taken;
    w = mdl[k][a];
    taken = '0;
    for (int p = 0; p < NP; p++) begin
      if (req[p] && we[p] && !rst &&
          int'(addr[p]) == a && a < dep(k)) begin
        for (int l = 0; l < NB; l++) begin
          if (be[p][l] && !taken[l]) begin
            w[l*8 +: 8] = wdata[p][l*8 +: 8];
            taken[l] = 1'b1;
          end
        end
      end
    end
    return w;
  endfunction

  task automatic model_step();
    exp_t e;
    logic [DW-1:0] nw [NP];
    int a;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < NP; p++) begin
        a = int'(addr[p]);
        if (req[p] && !we[p] && !rst) begin
          e.data = '0;
          if (a < dep(k))
            e.data = (k == 1) ? after_wr(k, a) : mdl[k][a];
          e.cyc = cyc + ws(k);
          sq[k*NP+p].push_back(e);
        end
      end
      for (int p = 0; p < NP; p++) begin
        nw[p] = after_wr(k, int'(addr[p]));
      end
      for (int p = 0; p < NP; p++) begin
        a = int'(addr[p]);
        if (req[p] && we[p] && !rst && a < dep(k))
          mdl[k][a] = nw[p];
      end
      for (int p = 0; p < NP; p++) begin
        for (int q = p + 1; q < NP; q++) begin
          if (req[p] && we[p] && req[q] && we[q] && !rst &&
              addr[p] == addr[q] && int'(addr[p]) < dep(k) &&
              |(be[p] & be[q]))
            coll_pend[k] = 1'b1;
        end
      end
    end
  endtask

  task automatic op(input int p, input bit w, input int a,
                    input logic [NB-1:0] b,
                    input logic [DW-1:0] d);
    n_req[p]  = 1'b1;
    n_we[p]   = w;
    n_addr[p] = AW'(a);
    n_be[p]   = b;
    n_wd[p]   = d;
  endtask

  task automatic clr();
    n_req = '0;
    n_we = '0;
    n_addr = '0;
    n_be = '0;
    n_wd = '0;
  endtask

  task automatic step(input logic r);
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 4; i++) sq[i].delete();
      for (int p = 0; p < NP; p++) last[1][p] = '0;
      coll_exp = '0;
    end else begin
`ifdef MEM_MODEL_MP_COLLISION_CHK_EN
      coll_exp = coll_exp | coll_pend;
`endif
    end
    coll_pend = '0;
    rst = r;
    req = n_req;
    we = n_we;
    addr = n_addr;
    be = n_be;
    wdata = n_wd;
    model_step();
    clr();
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    int i;
    if (mon_on) begin
      for (int k = 0; k < 2; k++) begin
        for (int p = 0; p < NP; p++) begin
          i = k * NP + p;
          if (rvalid[k][p]) begin
            if (sq[i].size() == 0) begin
              chk("spurious_rvalid", 1, 0);
            end else begin
              e = sq[i].pop_front();
              chk("rdata", rdata[k][p], e.data);
              chk("rd_cycle", DW'(cyc), DW'(e.cyc));
              last[k][p] = e.data;
            end
          end else begin
            if (sq[i].size() != 0 && sq[i][0].cyc <= cyc) begin
              chk("missing_rvalid", 0, 1);
              void'(sq[i].pop_front());
            end
            if (k == 1) chk("rdata_hold", rdata[k][p], last[k][p]);
          end
        end
        chk("coll_err", DW'(coll[k]), DW'(coll_exp[k]));
      end
    end
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 1024; a++) mdl[k][a] = '0;
      for (int p = 0; p < NP; p++) last[k][p] = '0;
    end
    clr();
    step(1'b1);
    step(1'b1);
    mon_on = 1'b1;
    step(1'b1);
    step(1'b0);
    @(negedge clk);
    chk("reset_rvalid", DW'(rvalid), '0);
    chk("reset_rdata_b", rdata[1], '0);
    chk("reset_coll", DW'(coll), '0);

    // partial-lane write then read back
    op(0, 1, 5, 16'h00FF, {16{8'h11}});
    step(1'b0);
    op(0, 0, 5, '0, '0);
    step(1'b0);

    // back-to-back reads on port 1
    for (int a = 0; a < 8; a++) begin
      op(1, 1, a, 16'hFFFF, {16{8'(a + 8'h30)}});
      step(1'b0);
    end
    for (int a = 0; a < 8; a++) begin
      op(1, 0, a, '0, '0);
      step(1'b0);
    end

    // read-during-write from the other port
    op(0, 1, 9, 16'hFFFF, {16{8'h55}});
    step(1'b0);
    op(0, 1, 9, 16'hFFFF, {16{8'hAA}});
    op(1, 0, 9, '0, '0);
    step(1'b0);

    // write-write overlap on one word
    op(0, 1, 3, 16'h000F, {16{8'hA1}});
    op(1, 1, 3, 16'h00FF, {16{8'hB2}});
    step(1'b0);
    op(0, 0, 3, '0, '0);
    step(1'b0);
    step(1'b0);

    // reset one cycle after a read is issued
    op(1, 0, 4, '0, '0);
    step(1'b0);
    step(1'b1);
    op(1, 0, 4, '0, '0);
    step(1'b0);
    for (int j = 0; j < 5; j++) step(1'b0);

    // out-of-range word and its neighbour
    op(0, 1, 1000, 16'hFFFF, {16{8'h77}});
    op(1, 1, 999, 16'hFFFF, {16{8'h66}});
    step(1'b0);
    op(0, 0, 1000, '0, '0);
    op(1, 0, 999, '0, '0);
    step(1'b0);
    for (int j = 0; j < 5; j++) step(1'b0);

    // random traffic with occasional reset
    for (int n = 0; n < 400; n++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) != 0) begin
          op(p, 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0) ?
               int'($urandom_range(990, 1023)) :
               int'($urandom_range(0, 15)),
             NB'($urandom),
             {$urandom, $urandom, $urandom, $urandom});
        end
      end
      step($urandom_range(0, 59) == 0);
    end
    for (int j = 0; j < 8; j++) step(1'b0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) chk("drain", DW'(sq[i].size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
